// File: rtl/yuv422_to_yuv444_ip.sv
// 4:2:2 -> 4:4:4 chroma upsampler: pairs interleaved {Y,C} words into full {Y,Cb,Cr} pixels,
// with optional linear interpolation of the odd pixel's chroma.
module yuv422_to_yuv444_ip #(
  parameter int DW       = 8,
  parameter bit CB_FIRST = 1'b1,
  parameter bit INTERP   = 1'b0
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [2*DW-1:0] iYCbCr,
  input  logic          iYCbCr_valid,
  input  logic          iSOL,
  input  logic          iEOL,
  output logic [DW-1:0] oY,
  output logic [DW-1:0] oCb,
  output logic [DW-1:0] oCr,
  output logic          oYCbCr_valid,
  output logic          oSOL,
  output logic          oEOL
);

  localparam int PW = 3*DW + 2;  // {Y, Cb, Cr, sol, eol}
  localparam int LW = 7;         // queued pixels plus up to three new ones per cycle

  typedef enum logic {EVEN, ODD} phase_t;

  phase_t          phaseReg, phaseNext;
  logic [DW-1:0]   y0Reg, y0Next, cFirstReg, cFirstNext;
  logic [DW-1:0]   lastCbReg, lastCbNext, lastCrReg, lastCrNext;
  logic            solReg, solNext;
  logic            pendValidReg, pendValidNext;
  logic [DW-1:0]   pendYReg, pendYNext, pendCbReg, pendCbNext, pendCrReg, pendCrNext;
  logic [PW-1:0]   qReg [LW];
  logic [PW-1:0]   qNext [LW];
  logic [2:0]      qCntReg, qCntNext;

  logic [PW-1:0]   newPix [3];
  logic [1:0]      newCnt;
  logic [PW-1:0]   merged [LW];
  logic [3:0]      total;
  logic [PW-1:0]   outPix;
  logic            outValid;

  logic [DW-1:0]   inY, inC, pairCb, pairCr, avgCb, avgCr;
  logic [DW:0]     sumCb, sumCr;
  logic            evenWord, solNow;

  assign inY    = iYCbCr[2*DW-1:DW];
  assign inC    = iYCbCr[DW-1:0];
  assign pairCb = CB_FIRST ? cFirstReg : inC;
  assign pairCr = CB_FIRST ? inC : cFirstReg;
  assign sumCb  = {1'b0, pendCbReg} + {1'b0, pairCb} + {{DW{1'b0}}, 1'b1};
  assign sumCr  = {1'b0, pendCrReg} + {1'b0, pairCr} + {{DW{1'b0}}, 1'b1};
  assign avgCb  = sumCb[DW:1];
  assign avgCr  = sumCr[DW:1];
  assign evenWord = iSOL || (phaseReg == EVEN);
  assign solNow   = iSOL || solReg;

  always_comb begin
    phaseNext     = phaseReg;
    y0Next        = y0Reg;
    cFirstNext    = cFirstReg;
    lastCbNext    = lastCbReg;
    lastCrNext    = lastCrReg;
    solNext       = solReg;
    pendValidNext = pendValidReg;
    pendYNext     = pendYReg;
    pendCbNext    = pendCbReg;
    pendCrNext    = pendCrReg;
    newCnt        = 2'd0;
    for (int i = 0; i < 3; i++) newPix[i] = '0;

    if (iYCbCr_valid) begin
      if (iSOL) begin
        solNext = 1'b1;
        if (INTERP && pendValidReg) begin
          newPix[newCnt] = {pendYReg, pendCbReg, pendCrReg, 1'b0, 1'b1};
          newCnt = newCnt + 2'd1;
          pendValidNext = 1'b0;
        end
      end
      if (evenWord) begin
        if (iEOL) begin
          // odd-length line: pending pixel first, then the orphan with last pair's chroma
          if (INTERP && pendValidReg && !iSOL) begin
            newPix[newCnt] = {pendYReg, pendCbReg, pendCrReg, 1'b0, 1'b0};
            newCnt = newCnt + 2'd1;
            pendValidNext = 1'b0;
          end
          newPix[newCnt] = {inY, lastCbReg, lastCrReg, solNow, 1'b1};
          newCnt    = newCnt + 2'd1;
          solNext   = 1'b0;
          phaseNext = EVEN;
        end else begin
          y0Next     = inY;
          cFirstNext = inC;
          phaseNext  = ODD;
        end
      end else begin
        lastCbNext = pairCb;
        lastCrNext = pairCr;
        if (INTERP && pendValidReg) begin
          newPix[newCnt] = {pendYReg, avgCb, avgCr, 1'b0, 1'b0};
          newCnt = newCnt + 2'd1;
        end
        newPix[newCnt] = {y0Reg, pairCb, pairCr, solReg, 1'b0};
        newCnt  = newCnt + 2'd1;
        solNext = 1'b0;
        if (!INTERP || iEOL) begin
          newPix[newCnt] = {inY, pairCb, pairCr, 1'b0, iEOL};
          newCnt = newCnt + 2'd1;
          pendValidNext = 1'b0;
        end else begin
          pendYNext     = inY;
          pendCbNext    = pairCb;
          pendCrNext    = pairCr;
          pendValidNext = 1'b1;
        end
        phaseNext = EVEN;
      end
    end
  end

  // Output queue with bypass: queued pixels drain first, then this cycle's new ones.
  always_comb begin
    int idx;
    for (int i = 0; i < LW; i++) begin
      merged[i] = '0;
      idx = i - int'(qCntReg);
      if (i < int'(qCntReg)) merged[i] = qReg[i];
      else if (idx >= 0 && idx < 3) merged[i] = newPix[2'(idx)];
    end
    total    = {1'b0, qCntReg} + {2'b00, newCnt};
    outValid = (total != 4'd0);
    outPix   = merged[0];
    qCntNext = outValid ? 3'(total - 4'd1) : 3'd0;
    for (int i = 0; i < LW - 1; i++) qNext[i] = merged[i+1];
    qNext[LW-1] = '0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      phaseReg     <= EVEN;
      y0Reg        <= '0;
      cFirstReg    <= '0;
      lastCbReg    <= '0;
      lastCrReg    <= '0;
      solReg       <= 1'b0;
      pendValidReg <= 1'b0;
      pendYReg     <= '0;
      pendCbReg    <= '0;
      pendCrReg    <= '0;
      qCntReg      <= '0;
      for (int i = 0; i < LW; i++) qReg[i] <= '0;
      oY           <= '0;
      oCb          <= '0;
      oCr          <= '0;
      oYCbCr_valid <= 1'b0;
      oSOL         <= 1'b0;
      oEOL         <= 1'b0;
    end else begin
      phaseReg     <= phaseNext;
      y0Reg        <= y0Next;
      cFirstReg    <= cFirstNext;
      lastCbReg    <= lastCbNext;
      lastCrReg    <= lastCrNext;
      solReg       <= solNext;
      pendValidReg <= pendValidNext;
      pendYReg     <= pendYNext;
      pendCbReg    <= pendCbNext;
      pendCrReg    <= pendCrNext;
      qCntReg      <= qCntNext;
      for (int i = 0; i < LW; i++) qReg[i] <= qNext[i];
      oYCbCr_valid <= outValid;
      oSOL         <= outValid && outPix[1];
      oEOL         <= outValid && outPix[0];
      if (outValid) begin
        oY  <= outPix[3*DW+1:2*DW+2];
        oCb <= outPix[2*DW+1:DW+2];
        oCr <= outPix[DW+1:2];
      end
    end
  end

endmodule

// File: tb/tb_yuv422_to_yuv444_ip.sv
// Directed bench for the 4:2:2 -> 4:4:4 upsampler; three instances cover
// replicate/Cb-first, replicate/Cr-first and interpolate modes on shared stimulus.
module tb_yuv422_to_yuv444_ip;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [15:0] iYCbCr = '0;
  logic        iYCbCr_valid = 1'b0;
  logic        iSOL = 1'b0;
  logic        iEOL = 1'b0;
  logic [7:0]  oYA [3];
  logic [7:0]  oCbA [3];
  logic [7:0]  oCrA [3];
  logic        oVA [3];
  logic        oSA [3];
  logic        oEA [3];
  logic [26:0] exp;
  int          tests = 0;
  int          fails = 0;

  always #5 iCLK = ~iCLK;

  yuv422_to_yuv444_ip #(.DW(8), .CB_FIRST(1'b1), .INTERP(1'b0)) u0 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iYCbCr(iYCbCr), .iYCbCr_valid(iYCbCr_valid),
    .iSOL(iSOL), .iEOL(iEOL), .oY(oYA[0]), .oCb(oCbA[0]), .oCr(oCrA[0]),
    .oYCbCr_valid(oVA[0]), .oSOL(oSA[0]), .oEOL(oEA[0]));
  yuv422_to_yuv444_ip #(.DW(8), .CB_FIRST(1'b0), .INTERP(1'b0)) u1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iYCbCr(iYCbCr), .iYCbCr_valid(iYCbCr_valid),
    .iSOL(iSOL), .iEOL(iEOL), .oY(oYA[1]), .oCb(oCbA[1]), .oCr(oCrA[1]),
    .oYCbCr_valid(oVA[1]), .oSOL(oSA[1]), .oEOL(oEA[1]));
  yuv422_to_yuv444_ip #(.DW(8), .CB_FIRST(1'b1), .INTERP(1'b1)) u2 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iYCbCr(iYCbCr), .iYCbCr_valid(iYCbCr_valid),
    .iSOL(iSOL), .iEOL(iEOL), .oY(oYA[2]), .oCb(oCbA[2]), .oCr(oCrA[2]),
    .oYCbCr_valid(oVA[2]), .oSOL(oSA[2]), .oEOL(oEA[2]));

  function automatic logic [26:0] pix(int k);
    return {oVA[k], oSA[k], oEA[k], oYA[k], oCbA[k], oCrA[k]};
  endfunction

  function automatic logic [26:0] mk(logic v, logic s, logic e, logic [7:0] y, logic [7:0] cb, logic [7:0] cr);
    return {v, s, e, y, cb, cr};
  endfunction

  // Present one word (or an idle cycle) for one clock; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic v, input logic [7:0] y, input logic [7:0] c, input logic s, input logic e);
    iYCbCr_valid = v;
    iYCbCr = {y, c};
    iSOL = s;
    iEOL = e;
    @(posedge iCLK);
    #1;
    iYCbCr_valid = 1'b0;
    iSOL = 1'b0;
    iEOL = 1'b0;
    $display("[TB] word v=%0d y=%0d c=%0d sol=%0d eol=%0d -> u0=%h u1=%h u2=%h",
             v, y, c, s, e, pix(0), pix(1), pix(2));
  endtask

  task automatic reset_dut();
    iRST_N = 1'b0;
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (pix(k) !== 27'd0) begin fails++; $display("FAIL reset_u%0d got=%h exp=0", k, pix(k)); end
    end
    iRST_N = 1'b1;
  endtask

  task automatic test_replicate();
    reset_dut();
    cyc(1, 10, 80, 1, 0);
    tests++;
    if (oVA[0] !== 1'b0) begin fails++; $display("FAIL repl_even_novalid got=%b exp=0", oVA[0]); end
    cyc(1, 20, 90, 0, 0);
    exp = mk(1, 1, 0, 10, 80, 90); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL repl_p0 got=%h exp=%h", pix(0), exp); end
    exp = mk(1, 1, 0, 10, 90, 80); tests++;
    if (pix(1) !== exp) begin fails++; $display("FAIL crfirst_p0 got=%h exp=%h", pix(1), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 0, 20, 80, 90); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL repl_p1 got=%h exp=%h", pix(0), exp); end
    exp = mk(1, 0, 0, 20, 90, 80); tests++;
    if (pix(1) !== exp) begin fails++; $display("FAIL crfirst_p1 got=%h exp=%h", pix(1), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(0, 0, 0, 20, 80, 90); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL repl_hold got=%h exp=%h", pix(0), exp); end
  endtask

  task automatic test_idle_gap();
    reset_dut();
    cyc(1, 10, 80, 1, 0);
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (oVA[0] !== 1'b0) begin fails++; $display("FAIL gap_idle_valid got=%b exp=0", oVA[0]); end
    cyc(1, 20, 90, 0, 1);
    exp = mk(1, 1, 0, 10, 80, 90); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL gap_p0 got=%h exp=%h", pix(0), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 1, 20, 80, 90); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL gap_p1_eol got=%h exp=%h", pix(0), exp); end
  endtask

  task automatic test_interp();
    reset_dut();
    cyc(1, 10, 100, 1, 0);
    cyc(1, 20, 50, 0, 0);
    exp = mk(1, 1, 0, 10, 100, 50); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL interp_p0n got=%h exp=%h", pix(2), exp); end
    cyc(1, 30, 201, 0, 0);
    tests++;
    if (oVA[2] !== 1'b0) begin fails++; $display("FAIL interp_pending_novalid got=%b exp=0", oVA[2]); end
    exp = mk(1, 0, 0, 20, 100, 50); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL interp_ref_repl got=%h exp=%h", pix(0), exp); end
    cyc(1, 40, 61, 0, 1);
    exp = mk(1, 0, 0, 20, 151, 56); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL interp_avg got=%h exp=%h", pix(2), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 0, 30, 201, 61); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL interp_p0n1 got=%h exp=%h", pix(2), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 1, 40, 201, 61); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL interp_p1_eol got=%h exp=%h", pix(2), exp); end
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (oVA[2] !== 1'b0) begin fails++; $display("FAIL interp_drained got=%b exp=0", oVA[2]); end
  endtask

  task automatic test_sol_realign();
    reset_dut();
    cyc(1, 10, 80, 1, 0);
    cyc(1, 20, 90, 1, 0);
    tests++;
    if (oVA[0] !== 1'b0) begin fails++; $display("FAIL realign_spurious got=%b exp=0", oVA[0]); end
    cyc(1, 30, 70, 0, 0);
    exp = mk(1, 1, 0, 20, 90, 70); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL realign_p0 got=%h exp=%h", pix(0), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 0, 30, 90, 70); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL realign_p1 got=%h exp=%h", pix(0), exp); end
  endtask

  task automatic test_sol_flush();
    reset_dut();
    cyc(1, 10, 100, 1, 0);
    cyc(1, 20, 50, 0, 0);
    cyc(1, 30, 201, 1, 0);
    exp = mk(1, 0, 1, 20, 100, 50); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL flush_pending got=%h exp=%h", pix(2), exp); end
    cyc(1, 40, 61, 0, 1);
    exp = mk(1, 1, 0, 30, 201, 61); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL flush_next_p0 got=%h exp=%h", pix(2), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 1, 40, 201, 61); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL flush_next_p1 got=%h exp=%h", pix(2), exp); end
  endtask

  task automatic test_orphan();
    reset_dut();
    cyc(1, 10, 80, 1, 0);
    cyc(1, 20, 90, 0, 0);
    cyc(1, 30, 55, 0, 1);
    exp = mk(1, 0, 0, 20, 80, 90);
    for (int k = 0; k < 3; k += 2) begin
      tests++;
      if (pix(k) !== exp) begin fails++; $display("FAIL orphan_prev_u%0d got=%h exp=%h", k, pix(k), exp); end
    end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 1, 30, 80, 90);
    for (int k = 0; k < 3; k += 2) begin
      tests++;
      if (pix(k) !== exp) begin fails++; $display("FAIL orphan_pix_u%0d got=%h exp=%h", k, pix(k), exp); end
    end
  endtask

  task automatic test_one_word_line();
    reset_dut();
    cyc(1, 50, 33, 1, 1);
    exp = mk(1, 1, 1, 50, 0, 0); tests++;
    if (pix(0) !== exp) begin fails++; $display("FAIL one_word got=%h exp=%h", pix(0), exp); end
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (oVA[0] !== 1'b0) begin fails++; $display("FAIL one_word_single got=%b exp=0", oVA[0]); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    cyc(1, 10, 100, 1, 0);
    cyc(1, 20, 50, 0, 0);
    cyc(1, 30, 201, 0, 0);
    iRST_N = 1'b0;
    #1;
    for (int k = 0; k < 3; k += 2) begin
      tests++;
      if (pix(k) !== 27'd0) begin fails++; $display("FAIL midreset_u%0d got=%h exp=0", k, pix(k)); end
    end
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    cyc(1, 60, 10, 0, 0);
    cyc(1, 70, 20, 0, 1);
    exp = mk(1, 0, 0, 60, 10, 20); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL midreset_p0 got=%h exp=%h", pix(2), exp); end
    cyc(0, 0, 0, 0, 0);
    exp = mk(1, 0, 1, 70, 10, 20); tests++;
    if (pix(2) !== exp) begin fails++; $display("FAIL midreset_p1 got=%h exp=%h", pix(2), exp); end
  endtask

  initial begin
    test_reset();
    test_replicate();
    test_idle_gap();
    test_interp();
    test_sol_realign();
    test_sol_flush();
    test_orphan();
    test_one_word_line();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/yuv422_to_yuv444_ip.md
Name: yuv422_to_yuv444_ip

Overview:
Parametrised successor to the fixed 8-bit 4:2:2→4:4:4 upsampler in the video pipeline. It sits between the capture/decoder stage and colour-space conversion.
- Input: interleaved 4:2:2 words {Y,C}.
- Output: one fully populated {Y,Cb,Cr} pixel per accepted luma sample.
- Chroma phase tracks accepted words only (not free-running) and resynchronises at start of line.
- Two chroma reconstruction modes: pair replication, or linear interpolation of the odd pixel.

Parameters:
DW        8  component width in bits.
CB_FIRST  1  1: first word of a pair carries Cb, second carries Cr; 0: reversed.
INTERP    0  0: replicate pair chroma to both pixels; 1: odd pixel chroma = rounded average of this pair's and next pair's chroma.

Ports:
iCLK           in   1     clock, rising edge.
iRST_N         in   1     asynchronous active-low reset.
iYCbCr         in   2*DW  {Y[2DW-1:DW], C[DW-1:0]}.
iYCbCr_valid   in   1     word qualifier; no backpressure.
iSOL           in   1     start of line; qualified by valid; marks first word of a line.
iEOL           in   1     end of line; qualified by valid; marks last word of a line.
oY             out  DW    luma.
oCb            out  DW    blue-difference chroma.
oCr            out  DW    red-difference chroma.
oYCbCr_valid   out  1     output pixel qualifier.
oSOL           out  1     with first output pixel of a line.
oEOL           out  1     with last output pixel of a line.

Behaviour:
- Reset (async, iRST_N low): all outputs 0, phase=even, all holding registers cleared, no pending pixel. Deassertion is sampled on iCLK. Reset mid-line discards all partial and pending data.
- Phase toggles only on accepted words (valid=1). Idle cycles never change phase.
- Accepted word with iSOL=1:
  - Forces even phase; any held even word is discarded.
  - If INTERP=1 and a pixel is pending, it is flushed with replicated chroma on the following cycle, with oEOL=1.
- Even word: latch Y0 and C_first. Odd word: latch Y1 and C_second, completing pair n.
- Chroma mapping:
  - CB_FIRST=1: C_first→Cb, C_second→Cr.
  - CB_FIRST=0: the reverse.
- INTERP=0:
  - P0 = {Y0,Cb,Cr} is emitted the cycle after the odd word is accepted.
  - P1 = {Y1,Cb,Cr} is emitted the cycle after that.
  - Latency is 2 cycles per pixel for back-to-back input. Full-rate input never collides, because outputs are 2 per pair.
- INTERP=1:
  - P1 of pair n is held pending until pair n+1 completes.
  - When pair n+1 completes: cycle+1 emits P1(n), with Cb=(Cb_n+Cb_n+1+1)>>1 and Cr likewise. Compute with a DW+1-bit sum and no overflow. Cycle+2 emits P0(n+1).
  - If the odd word of pair n carries iEOL: P0(n) and P1(n) are emitted back-to-back with replicated chroma. Nothing stays pending.
- oSOL is asserted with P0 of the first pair after iSOL. oEOL is asserted with P1 of the pair whose odd word carried iEOL, or with a flushed pending pixel.
- iEOL on an even word (odd-length line):
  - The held even word is emitted alone the next cycle, using the last completed pair's chroma (0 if none), with oEOL=1.
  - Phase returns to even.
  - In INTERP mode, any pending pixel is emitted first; the orphan follows one cycle later.
- Simultaneous iSOL and iEOL on one word: treated as a one-word line; output is one pixel with oSOL=oEOL=1.
- Outputs are registered. oY/oCb/oCr hold their last value while oYCbCr_valid=0.

Test Plan:
- Reset, then INTERP=0, CB_FIRST=1, back-to-back words {10,80},{20,90} with iSOL on the first word → out {10,80,90} with oSOL, then {20,80,90}, at cycles t+2 and t+3 from the first word.
- Same pair with one idle cycle between the words → phase holds; outputs are identical, with the first pixel one cycle after the second word.
- CB_FIRST=0 with {10,80},{20,90} → {10,90,80},{20,90,80}.
- INTERP=1, pairs {10,100},{20,50} and {30,201},{40,61} (Cb 100→201, Cr 50→61), iEOL on the last word:
  - P1 of pair 0 has Cb=151, Cr=56.
  - Pair 1 pixels are replicated, {30,201,61},{40,201,61}, with oEOL on the last.
- iSOL asserted on what would be an odd word → previous even word dropped, phase re-aligned; no spurious output pixel.
- Assert iRST_N low mid-pair and mid-pending (INTERP=1) → all outputs 0 immediately; the first pair after release behaves exactly as from power-up.
